// File: rtl/parallel_to_serial.sv
// Parallel-in/serial-out shifter with a valid/ready load port.
// Streams one WIDTH-bit word out a bit per enabled clk, framed by valid/last/done.
module parallel_to_serial #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] datain,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             load_ready_q, load_ready_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        count_d        = count_q;
        load_ready_d   = load_ready_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        last_bit_d     = last_bit_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready_d = 1'b1;
                if (load_valid && load_ready_q) begin
                    state_d        = SHIFT;
                    shreg_d        = datain;
                    count_d        = '0;
                    load_ready_d   = 1'b0;
                    busy_d         = 1'b1;
                    serial_valid_d = 1'b1;
                    last_bit_d     = 1'b0;
                    serial_out_d   = MSB_FIRST ? datain[WIDTH-1] : datain[0];
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (count_q == LAST) begin
                        state_d        = IDLE;
                        serial_valid_d = 1'b0;
                        serial_out_d   = 1'b0;
                        last_bit_d     = 1'b0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                        load_ready_d   = 1'b1;
                    end else begin
                        count_d    = count_q + CW'(1);
                        last_bit_d = (count_d == LAST);
                        // The register shifts so the next bit is always adjacent to the head.
                        if (MSB_FIRST) begin
                            shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
                            serial_out_d = shreg_q[WIDTH-2];
                        end else begin
                            shreg_d      = {1'b0, shreg_q[WIDTH-1:1]};
                            serial_out_d = shreg_q[1];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            count_q        <= '0;
            load_ready_q   <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            last_bit_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            count_q        <= count_d;
            load_ready_q   <= load_ready_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            last_bit_q     <= last_bit_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign last_bit     = last_bit_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a queue-of-bits frame model.
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       clear;
    logic       load_valid;
    logic       shift_en;
    logic [3:0] datain;

    logic m_ready, m_out, m_valid, m_last, m_busy, m_done;
    logic l_ready, l_out, l_valid, l_last, l_busy, l_done;

    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clear(clear), .datain(datain),
        .load_valid(load_valid), .load_ready(m_ready),
        .shift_en(shift_en), .serial_out(m_out),
        .serial_valid(m_valid), .last_bit(m_last),
        .busy(m_busy), .done(m_done)
    );

    parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clear(clear), .datain(datain),
        .load_valid(load_valid), .load_ready(l_ready),
        .shift_en(shift_en), .serial_out(l_out),
        .serial_valid(l_valid), .last_bit(l_last),
        .busy(l_busy), .done(l_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the bits still to be sent in the current frame.
    bit qm[$];
    bit ql[$];
    bit e_ready;
    bit e_done;

    logic [3:0] rx;
    logic [3:0] s;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        qm.delete();
        ql.delete();
        e_ready = 1'b0;
        e_done  = 1'b0;
    endfunction

    function automatic void model_edge();
        if (clear) begin
            model_reset();
        end else if (qm.size() == 0) begin
            e_done = 1'b0;
            if (e_ready && load_valid) begin
                for (int i = 0; i < 4; i++) begin
                    qm.push_back(datain[3-i]);
                    ql.push_back(datain[i]);
                end
                e_ready = 1'b0;
            end else begin
                e_ready = 1'b1;
            end
        end else begin
            e_done = 1'b0;
            if (shift_en) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                if (qm.size() == 0) begin
                    e_done  = 1'b1;
                    e_ready = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_all();
        bit act;
        act = (qm.size() != 0);
        chk1("m_ready", m_ready, e_ready);
        chk1("m_valid", m_valid, act);
        chk1("m_out",   m_out,   act ? qm[0] : 1'b0);
        chk1("m_last",  m_last,  qm.size() == 1);
        chk1("m_busy",  m_busy,  act);
        chk1("m_done",  m_done,  e_done);
        chk1("l_ready", l_ready, e_ready);
        chk1("l_valid", l_valid, act);
        chk1("l_out",   l_out,   act ? ql[0] : 1'b0);
        chk1("l_last",  l_last,  ql.size() == 1);
        chk1("l_busy",  l_busy,  act);
        chk1("l_done",  l_done,  e_done);
    endtask

    task automatic step();
        if (!clear && l_valid && shift_en)
            rx = {l_out, rx[3:1]};
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Stream the MSB-first word of a frame already showing its first bit.
    task automatic collect4();
        for (int i = 0; i < 4; i++) begin
            s[3-i] = m_out;
            step();
        end
    endtask

    initial begin
        int vlen;
        clear      = 1'b1;
        load_valid = 1'($urandom);
        shift_en   = 1'($urandom);
        datain     = 4'($urandom);
        rx         = '0;
        s          = '0;
        model_reset();
        #2;
        check_all();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'($urandom);
            shift_en   = 1'($urandom);
            datain     = 4'($urandom);
            step();
        end

        clear      = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b1;
        step();
        chk1("t1_ready_after_release", m_ready, 1'b1);

        // Basic MSB-first frame.
        datain     = 4'b1011;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        collect4();
        chk4("t2_stream", s, 4'b1011);
        chk1("t2_done", m_done, 1'b1);

        // Back-to-back load on the done cycle, with a 3-cycle stall.
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        vlen = 0;
        for (int c = 0; c < 20 && m_valid; c++) begin
            vlen++;
            shift_en = (c == 0 || c >= 4);
            step();
        end
        shift_en = 1'b1;
        chk4("t3_valid_len", 4'(vlen), 4'd7);

        // LSB-first instance feeds a 4-stage receiver.
        step();
        datain     = 4'b0010;
        load_valid = 1'b1;
        rx         = '0;
        step();
        load_valid = 1'b0;
        collect4();
        chk4("t4_rx_word", rx, 4'b0010);

        // Load offered while busy is ignored until done.
        datain     = 4'h5;
        load_valid = 1'b1;
        step();
        datain = 4'hF;
        collect4();
        chk4("t5_stream", s, 4'h5);
        step();
        load_valid = 1'b0;
        collect4();
        chk4("t5_second", s, 4'hF);

        // Async clear mid-frame.
        step();
        datain     = 4'b1100;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        clear = 1'b0;
        step();
        datain     = 4'b0110;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        collect4();
        chk4("t6_stream", s, 4'b0110);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            load_valid = 1'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            datain     = 4'($urandom);
            clear      = ($urandom_range(0, 39) == 0);
            step();
        end
        clear = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
